// File: rtl/simplecore_pkg.sv
// Shared SimpleCore definitions: shift-control encodings, sequencer states
// and shift-control decode helpers.
package simplecore_pkg;

  localparam logic [2:0] SHCTL_LSL = 3'b000;
  localparam logic [2:0] SHCTL_LSR = 3'b100;
  localparam logic [2:0] SHCTL_ASR = 3'b101;
  localparam logic [2:0] SHCTL_ROR = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // 0?? selects a left shift
  function automatic logic ctl_is_lsl(input logic [2:0] c);
    return ~c[2];
  endfunction

  // 11? selects a rotate right
  function automatic logic ctl_is_ror(input logic [2:0] c);
    return c[2] & c[1];
  endfunction

  // 101 selects an arithmetic right shift
  function automatic logic ctl_is_asr(input logic [2:0] c);
    return (c == SHCTL_ASR);
  endfunction

endpackage

// File: rtl/shift32_seq_shifter.sv
// 16-bit barrel shifter: LSL, LSR, ASR and ROR by 0..15, purely combinational.
module shifter
  import simplecore_pkg::*;
(
  input  logic [15:0] data_i,
  input  logic [3:0]  amt_i,
  input  logic [2:0]  ctl_i,
  output logic [15:0] data_o
);

  logic signed [15:0] asr_val;
  logic        [15:0] ror_val;

  // Select the shift flavour; a rotate by 0 leaves the word unchanged
  always_comb begin
    asr_val = $signed(data_i) >>> amt_i;
    ror_val = (data_i >> amt_i) | (data_i << (5'd16 - {1'b0, amt_i}));
    if (ctl_is_lsl(ctl_i)) begin
      data_o = data_i << amt_i;
    end else if (ctl_is_ror(ctl_i)) begin
      data_o = ror_val;
    end else if (ctl_i[0]) begin
      data_o = asr_val;
    end else begin
      data_o = data_i >> amt_i;
    end
  end

endmodule

// File: rtl/shift32_seq.sv
// 32-bit shift/rotate sequencer built around one 16-bit shifter.
// Amount bit 4 is handled by a word pre-swap at accept; the remaining 0..15
// is done in three shifter passes (lo-part, hi-part, spill) and merged.
module shift32_seq
  import simplecore_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shiftCtl,
  input  logic [4:0]  shiftAmt,
  input  logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout
);

  state_t      st_q, st_d;
  logic [2:0]  ctl_q;
  logic [3:0]  k_q;
  logic [15:0] h_q, l_q, h_d, l_d;
  logic [15:0] r1_q, r2_q, r3_q;
  logic [31:0] dout_q, asm_d;
  logic        done_q;

  logic [15:0] sh_in, sh_out;
  logic [3:0]  sh_amt;
  logic [2:0]  sh_ctl;
  logic [15:0] hmask, lmask;

  assign busy = (st_q != ST_IDLE);
  assign done = done_q;
  assign dout = dout_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state: start only counts in IDLE, passes advance unconditionally
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (start) st_d = ST_P1;
      ST_P1:   st_d = ST_P2;
      ST_P2:   st_d = ST_P3;
      ST_P3:   st_d = ST_DONE;
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Pre-swap for amounts of 16 and above so only a 0..15 shift remains
  always_comb begin
    h_d = din[31:16];
    l_d = din[15:0];
    if (shiftAmt[4]) begin
      if (ctl_is_lsl(shiftCtl)) begin
        h_d = din[15:0];
        l_d = 16'h0000;
      end else if (ctl_is_ror(shiftCtl)) begin
        h_d = din[15:0];
        l_d = din[31:16];
      end else if (ctl_is_asr(shiftCtl)) begin
        h_d = {16{din[31]}};
        l_d = din[31:16];
      end else begin
        h_d = 16'h0000;
        l_d = din[31:16];
      end
    end
  end

  // Shifter input mux per pass. P1 rotates L for ROR so its spill into the
  // hi word comes for free; P3 yields the spill of the other word.
  always_comb begin
    sh_in  = 16'h0000;
    sh_amt = 4'd0;
    sh_ctl = SHCTL_LSL;
    case (st_q)
      ST_P1: begin
        sh_in  = l_q;
        sh_amt = k_q;
        if (ctl_is_lsl(ctl_q))      sh_ctl = SHCTL_LSL;
        else if (ctl_is_ror(ctl_q)) sh_ctl = SHCTL_ROR;
        else                        sh_ctl = SHCTL_LSR;
      end
      ST_P2: begin
        sh_in  = h_q;
        sh_amt = k_q;
        if (ctl_is_lsl(ctl_q))      sh_ctl = SHCTL_LSL;
        else if (ctl_is_asr(ctl_q)) sh_ctl = SHCTL_ASR;
        else                        sh_ctl = SHCTL_LSR;
      end
      ST_P3: begin
        sh_ctl = SHCTL_ROR;
        if (ctl_is_lsl(ctl_q)) begin
          sh_in  = l_q;
          sh_amt = 4'd0 - k_q;
        end else begin
          sh_in  = h_q;
          sh_amt = k_q;
        end
      end
      default: ;
    endcase
  end

  shifter u_shifter (
    .data_i (sh_in),
    .amt_i  (sh_amt),
    .ctl_i  (sh_ctl),
    .data_o (sh_out)
  );

  // Merge pass results; a zero k gives empty masks so {H,L} passes through
  always_comb begin
    hmask = ~(16'hFFFF >> k_q);
    lmask = ~(16'hFFFF << k_q);
    if (ctl_is_lsl(ctl_q)) begin
      asm_d = {r2_q | (r3_q & lmask), r1_q};
    end else if (ctl_is_ror(ctl_q)) begin
      asm_d = {r2_q | (r1_q & hmask), (r1_q & ~hmask) | (r3_q & hmask)};
    end else begin
      asm_d = {r2_q, r1_q | (r3_q & hmask)};
    end
  end

  // Operand latch, per-pass captures and result/done registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q  <= 3'b000;
      k_q    <= 4'd0;
      h_q    <= 16'h0000;
      l_q    <= 16'h0000;
      r1_q   <= 16'h0000;
      r2_q   <= 16'h0000;
      r3_q   <= 16'h0000;
      dout_q <= 32'h0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            ctl_q <= shiftCtl;
            k_q   <= shiftAmt[3:0];
            h_q   <= h_d;
            l_q   <= l_d;
          end
        end
        ST_P1:   r1_q <= sh_out;
        ST_P2:   r2_q <= sh_out;
        ST_P3:   r3_q <= sh_out;
        ST_DONE: begin
          dout_q <= asm_d;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift32_seq.sv
// Directed bench for shift32_seq: vector table plus multi-cycle corner cases.
module tb_shift32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  shiftCtl;
  logic [4:0]  shiftAmt;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift32_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .shiftCtl (shiftCtl),
    .shiftAmt (shiftAmt),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout)
  );

  typedef struct {
    logic [2:0]  ctl;
    logic [4:0]  amt;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat = edges from accept
  task automatic run_op(input logic [2:0] c, input logic [4:0] a, input logic [31:0] d,
                        output int lat);
    @(negedge clk);
    shiftCtl = c;
    shiftAmt = a;
    din      = d;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    @(negedge clk);
    check32("busy_after_accept", {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int dcount;

    vecs[0]  = '{3'b000, 5'd1,  32'h0000_8001, 32'h0001_0002};
    vecs[1]  = '{3'b100, 5'd17, 32'h8000_0001, 32'h0000_4000};
    vecs[2]  = '{3'b101, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[3]  = '{3'b101, 5'd0,  32'h8000_0000, 32'h8000_0000};
    vecs[4]  = '{3'b110, 5'd8,  32'h1234_5678, 32'h7812_3456};
    vecs[5]  = '{3'b110, 5'd16, 32'h1234_5678, 32'h5678_1234};
    vecs[6]  = '{3'b110, 5'd20, 32'h1234_5678, 32'h4567_8123};
    vecs[7]  = '{3'b100, 5'd4,  32'h1234_5678, 32'h0123_4567};
    vecs[8]  = '{3'b101, 5'd8,  32'h8765_4321, 32'hFF87_6543};
    vecs[9]  = '{3'b000, 5'd20, 32'h1234_5678, 32'h6780_0000};
    vecs[10] = '{3'b110, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[11] = '{3'b110, 5'd31, 32'h0000_0001, 32'h0000_0002};
    vecs[12] = '{3'b100, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[13] = '{3'b011, 5'd1,  32'h0000_8001, 32'h0001_0002};
    vecs[14] = '{3'b111, 5'd12, 32'h1234_5678, 32'h6781_2345};

    reset    = 1'b1;
    start    = 1'b0;
    shiftCtl = 3'b000;
    shiftAmt = 5'd0;
    din      = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_busy", {31'b0, busy}, 32'd0);
    check32("reset_done", {31'b0, done}, 32'd0);
    check32("reset_dout", dout, 32'h0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].ctl, vecs[i].amt, vecs[i].din, lat);
      check32($sformatf("latency_v%0d", i), lat, 32'd4);
      check32($sformatf("dout_v%0d", i), dout, vecs[i].exp);
      check32($sformatf("busy_at_done_v%0d", i), {31'b0, busy}, 32'd0);
    end

    // start re-pulsed in P2 and in DONE must be ignored
    dcount = 0;
    @(negedge clk);
    shiftCtl = 3'b000; shiftAmt = 5'd1; din = 32'h0000_8001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;            // accept -> P1
    @(negedge clk); if (done) dcount++;
    @(posedge clk);                             // -> P2
    @(negedge clk); if (done) dcount++;
    start = 1'b1; din = 32'hFFFF_FFFF; shiftAmt = 5'd7;
    @(posedge clk); #1 start = 1'b0;            // -> P3
    @(negedge clk); if (done) dcount++;
    @(posedge clk);                             // -> DONE
    @(negedge clk); if (done) dcount++;
    check32("busy_in_done", {31'b0, busy}, 32'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;            // -> IDLE
    @(negedge clk);
    check32("repulse_done", {31'b0, done}, 32'd1);
    check32("repulse_busy_after", {31'b0, busy}, 32'd0);
    check32("repulse_dout", dout, 32'h0001_0002);
    if (done) dcount++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check32("repulse_done_count", dcount, 32'd1);
    check32("repulse_idle_busy", {31'b0, busy}, 32'd0);

    // reset asserted in P2 aborts the operation
    @(negedge clk);
    shiftCtl = 3'b110; shiftAmt = 5'd8; din = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;            // -> P1
    @(posedge clk);                             // -> P2
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check32("abort_busy", {31'b0, busy}, 32'd0);
    check32("abort_done", {31'b0, done}, 32'd0);
    check32("abort_dout", dout, 32'h0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check32("abort_no_done", dcount, 32'd0);
    check32("abort_stays_idle", {31'b0, busy}, 32'd0);

    run_op(3'b000, 5'd4, 32'h0000_000F, lat);
    check32("post_reset_latency", lat, 32'd4);
    check32("post_reset_dout", dout, 32'h0000_00F0);
    @(negedge clk);
    check32("done_single_pulse", {31'b0, done}, 32'd0);
    check32("dout_held", dout, 32'h0000_00F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
